pcihellocore_sw_edge_pio: RTL and testbench

PCIHELLOCORE_SW_EDGE_PIO -- requirements
Module: pcihellocore_sw_edge_pio

---
 rtl/pcihellocore_sw_edge_pio.sv | 131 +++++++++++++
 tb/tb_pcihellocore_sw_edge_pio.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcihellocore_sw_edge_pio.sv
// rtl/pcihellocore_sw_edge_pio.sv - Avalon-MM edge-capturing PIO for switches/keys
// Optional debounce filter enabled by defining PIO_DEBOUNCE_EN.
module pcihellocore_sw_edge_pio #(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [1:0]       sync_vld_q, sync_vld_d;
    logic             primed_q, primed_d;

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

`ifdef PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             tick;
    logic [WIDTH-1:0] stable;
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;
`endif

    always_comb begin
        s1_d       = in_port;
        s2_d       = s1_q;
        // sync_vld tracks when s2 holds a real pin sample rather than reset zeros,
        // so pins held high across reset never look like an edge.
        sync_vld_d = {sync_vld_q[0], 1'b1};
        wr_en      = chipselect & ~write_n;
        wdata      = writedata[WIDTH-1:0];

`ifdef PIO_DEBOUNCE_EN
        tick     = (cnt_q == CNT_MAX);
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        sample_d = sample_q;
        stable   = ~(s2_q ^ sample_q);
        load     = 1'b0;
        load_val = data_q;
        if (tick && sync_vld_q[1]) begin
            sample_d = s2_q;
            load     = 1'b1;
            // The priming tick takes the pins wholesale; later ticks only accept
            // bits that matched on two consecutive ticks.
            load_val = primed_q ? ((data_q & ~stable) | (s2_q & stable)) : s2_q;
        end
`else
        load     = sync_vld_q[1];
        load_val = s2_q;
`endif

        data_d   = load ? load_val : data_q;
        primed_d = primed_q | load;

        edge_set = (load && primed_q) ? (load_val ^ data_q) : '0;
        edge_clr = (wr_en && address == 2'd3) ? wdata : '0;
        // Set wins over a simultaneous clear.
        edge_capture_d = (edge_capture_q & ~edge_clr) | edge_set;

        irq_mask_d = (wr_en && address == 2'd2) ? wdata : irq_mask_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q           <= '0;
            s2_q           <= '0;
            data_q         <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            sync_vld_q     <= '0;
            primed_q       <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            data_q         <= data_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            sync_vld_q     <= sync_vld_d;
            primed_q       <= primed_d;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            sample_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
        end
    end
`endif

    always_comb begin
        readdata = 32'h0;
        case (address)
            2'd0:    readdata = 32'(data_q);
            2'd2:    readdata = 32'(irq_mask_q);
            2'd3:    readdata = 32'(edge_capture_q);
            default: readdata = 32'h0;
        endcase
    end

    assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_pcihellocore_sw_edge_pio.sv
// tb/tb_pcihellocore_sw_edge_pio.sv - randomized self-checking bench for the edge PIO
// Covers the PIO_DEBOUNCE_EN build as well when that macro is defined.
module tb_pcihellocore_sw_edge_pio;

    localparam int W  = 18;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_data, m_mask, m_edge, m_samp;
    bit           m_primed;
    int           m_k;
    logic [W-1:0] pq[$];

    pcihellocore_sw_edge_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_data = '0; m_mask = '0; m_edge = '0; m_samp = '0;
        m_primed = 0; m_k = 0; pq.delete();
    endtask

    // Data follows the pin as it stood two edges earlier; changes after priming are edges.
    task automatic model_edge();
        logic [W-1:0] nd, s, set, clr;
        bit ld;
        pq.push_back(in_port);
        if (pq.size() > 3) void'(pq.pop_front());
        m_k++;
        ld = 0; nd = m_data; set = '0; clr = '0;
        if (pq.size() == 3) begin
            s = pq[0];
`ifdef PIO_DEBOUNCE_EN
            if (m_k % DC == 0) begin
                ld = 1;
                for (int i = 0; i < W; i++)
                    if (!m_primed || s[i] == m_samp[i]) nd[i] = s[i];
                m_samp = s;
            end
`else
            ld = 1;
            nd = s;
`endif
        end
        if (ld && m_primed) set = nd ^ m_data;
        if (ld) m_primed = 1;
        m_data = nd;
        if (chipselect && !write_n) begin
            if (address == 2'd2) m_mask = writedata[W-1:0];
            if (address == 2'd3) clr = writedata[W-1:0];
        end
        m_edge = (m_edge & ~clr) | set;
    endtask

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_data);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_edge);
            default: return 32'h0;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        #1;
        checks++;
        if (irq !== (|(m_edge & m_mask))) begin
            errors++;
            $display("FAIL irq t=%0t got %0b exp %0b", $time, irq, |(m_edge & m_mask));
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cycle();
        chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; in_port = 18'h3FFFF; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0;
        model_reset();
        repeat (2) cycle();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", a, v); end
        end
        reset = 1'b0;
        repeat (5) cycle();
        rd(2'd0, v);
        checks++;
        if (v !== m_reg(2'd0)) begin errors++; $display("FAIL post_reset_data got %h exp %h", v, m_reg(2'd0)); end
`ifndef PIO_DEBOUNCE_EN
        checks++;
        if (v !== 32'h0003FFFF) begin errors++; $display("FAIL held_high_data got %h exp 0003ffff", v); end
`endif
        rd(2'd3, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL held_high_edge got %h exp 0", v); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] v, e;
        in_port = '0;
        repeat (16) cycle();
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'h1);
        in_port[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            rd(2'd0, v);
            rd(2'd3, e);
            checks++;
            if (v !== m_reg(2'd0) || e !== m_reg(2'd3)) begin
                errors++;
                $display("FAIL edge_track cyc%0d data %h/%h edge %h/%h", i, v, m_reg(2'd0), e, m_reg(2'd3));
            end
        end
        checks++;
        if (irq !== 1'b1 || e[0] !== 1'b1) begin errors++; $display("FAIL edge_irq_set irq=%0b edge=%h exp 1/1", irq, e); end
        wr(2'd3, 32'h1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_clear got %0b exp 0", irq); end
    endtask

`ifndef PIO_DEBOUNCE_EN
    task automatic test_set_clear_same_cycle();
        logic [31:0] v;
        wr(2'd3, 32'hFFFF_FFFF);
        in_port[5] = ~in_port[5];
        cycle();
        cycle();
        wr(2'd3, 32'h20);
        rd(2'd0, v);
        checks++;
        if (v[5] !== in_port[5]) begin errors++; $display("FAIL collide_data got %0b exp %0b", v[5], in_port[5]); end
        rd(2'd3, v);
        checks++;
        if (v[5] !== 1'b1 || v !== m_reg(2'd3)) begin errors++; $display("FAIL collide_edge got %h exp %h", v, m_reg(2'd3)); end
    endtask
`endif

    task automatic test_mask_late();
        logic [31:0] v;
        wr(2'd2, 32'h0);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port[3:0] = ~in_port[3:0];
        repeat (16) cycle();
        rd(2'd3, v);
        checks++;
        if (v !== 32'hF) begin errors++; $display("FAIL mask0_edges got %h exp 0000000f", v); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mask0_irq got %0b exp 0", irq); end
        wr(2'd2, 32'h8);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL mask8_irq got %0b exp 1", irq); end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [1:0]  a;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) in_port = W'($urandom);
            if ($urandom_range(3) == 0) wr(2'($urandom_range(3)), $urandom);
            else cycle();
            a = 2'($urandom_range(3));
            rd(a, v);
            checks++;
            if (v !== m_reg(a)) begin errors++; $display("FAIL rand_read%0d addr%0d got %h exp %h", i, a, v, m_reg(a)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(2'd2, 32'h3);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port[1:0] = ~in_port[1:0];
        repeat (16) cycle();
        rd(2'd3, v);
        checks++;
        if ((v & 32'h3) !== 32'h3 || irq !== 1'b1) begin errors++; $display("FAIL pre_reset edge=%h irq=%0b exp 3/1", v, irq); end
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_drop got %0b exp 0", irq); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL mid_reset_reg%0d got %h exp 0", a, v); end
        end
        cycle();
        reset = 1'b0;
        repeat (12) cycle();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== m_reg(2'(a))) begin errors++; $display("FAIL after_reset_reg%0d got %h exp %h", a, v, m_reg(2'(a))); end
        end
    endtask

`ifdef PIO_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] v;
        logic        lvl;
        repeat (12) cycle();
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd0, v);
        lvl = v[1];
        in_port[1] = ~lvl;
        repeat (3) cycle();
        in_port[1] = lvl;
        repeat (12) cycle();
        rd(2'd0, v);
        checks++;
        if (v[1] !== lvl || v !== m_reg(2'd0)) begin errors++; $display("FAIL glitch_data got %h exp %h", v, m_reg(2'd0)); end
        rd(2'd3, v);
        checks++;
        if (v[1] !== 1'b0) begin errors++; $display("FAIL glitch_edge got %h exp bit1=0", v); end
        in_port[1] = ~lvl;
        repeat (12) cycle();
        rd(2'd0, v);
        checks++;
        if (v[1] !== ~lvl) begin errors++; $display("FAIL steady_data got %0b exp %0b", v[1], ~lvl); end
        rd(2'd3, v);
        checks++;
        if (v[1] !== 1'b1 || v !== m_reg(2'd3)) begin errors++; $display("FAIL steady_edge got %h exp %h", v, m_reg(2'd3)); end
    endtask
`endif

    initial begin
        test_reset();
        test_edge_irq();
`ifndef PIO_DEBOUNCE_EN
        test_set_clear_same_cycle();
`endif
        test_mask_late();
        test_random();
        test_reset_mid();
`ifdef PIO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
